// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic SERIAL_IDLE_LEVEL    = 1'b1;
    localparam int   SERIAL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/rx_holding_reg.sv
// One-entry output buffer with valid/ready handshake, load/consume
// arbitration and overrun pulse generation.
module rx_holding_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             load_perr_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             parity_err_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             perr_q;
    logic             overrun_q;
    logic             can_accept;

    // A held word being consumed on this edge frees the slot for a same-edge load.
    assign can_accept = !valid_q || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= load_i && !can_accept;
            if (load_i && can_accept) begin
                data_q  <= load_data_i;
                perr_q  <= load_perr_i;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = overrun_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Start-bit detection, LSB-first data shifting, optional even parity and
// stop-bit checking; good words are handed to a one-entry holding register.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int   WIDTH     = SERIAL_WIDTH_DEFAULT,
    parameter logic PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_t        state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             par_bad_q;
    logic             frame_err_q;
    logic             stop_good;
    logic             load_perr;

    // Written as shift-then-insert so a one-bit word needs no special case.
    always_comb begin
        shreg_d            = shreg_q >> 1;
        shreg_d[WIDTH-1]   = din;
    end

    assign stop_good = (state_q == STOP) && bit_en && din;
    assign load_perr = PARITY_EN ? par_bad_q : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_bad_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (din != SERIAL_IDLE_LEVEL) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shreg_q   <= shreg_d;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= PARITY_EN ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        par_bad_q <= (^shreg_q) ^ din;
                        state_q   <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!din) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign frame_err = frame_err_q;

    rx_holding_reg #(
        .WIDTH(WIDTH)
    ) u_holding (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (stop_good),
        .load_data_i  (shreg_q),
        .load_perr_i  (load_perr),
        .ready_i      (ready),
        .data_o       (data_out),
        .valid_o      (valid),
        .parity_err_o (parity_err),
        .overrun_o    (overrun)
    );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed self-checking bench for serial_frame_receiver (WIDTH=8, parity on).
module tb_serial_frame_receiver;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       bit_en;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int nCompared;
    int nMismatched;

    serial_frame_receiver #(
        .WIDTH     (8),
        .PARITY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobed bit, preceded by gap cycles with bit_en low; returns just after the sampling edge.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            din    = 1'b1;
            bit_en = 1'b0;
        end
        @(negedge clk);
        din    = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic send_head(input logic [7:0] data, input logic par, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(data[i], gap);
        send_bit(par, gap);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop, input int gap);
        send_head(data, par, gap);
        send_bit(stop, gap);
        din = 1'b1;
    endtask

    task automatic consume_one();
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = 1'b1; bit_en = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nCompared += 5;
        if (data_out !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_data got=%h exp=00", data_out); end
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
        if (parity_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_perr got=%b exp=0", parity_err); end
        if (frame_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ferr got=%b exp=0", frame_err); end
        if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            din = 1'b1; bit_en = 1'b1;
            @(posedge clk);
            #1;
            nCompared++;
            if (valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL idle_quiet cyc=%0d got v/fe/ov=%b%b%b exp=000", i, valid, frame_err, overrun);
            end
        end
        bit_en = 1'b0;
    endtask

    task automatic test_good_frame();
        send_head(8'hA5, 1'b0, 0);
        nCompared++;
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL good_early_valid got=%b exp=0", valid); end
        send_bit(1'b1, 0);
        din = 1'b1;
        nCompared += 4;
        if (valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL good_valid got=%b exp=1", valid); end
        if (data_out !== 8'hA5) begin nMismatched++; $display("[TB] FAIL good_data got=%h exp=a5", data_out); end
        if (parity_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL good_perr got=%b exp=0", parity_err); end
        if (frame_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL good_ferr got=%b exp=0", frame_err); end
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if (valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL good_hold_valid got=%b exp=1", valid); end
        consume_one();
        nCompared += 2;
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL good_consumed_valid got=%b exp=0", valid); end
        if (data_out !== 8'hA5) begin nMismatched++; $display("[TB] FAIL good_kept_data got=%h exp=a5", data_out); end
    endtask

    task automatic test_parity_error();
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        nCompared += 3;
        if (valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL perr_valid got=%b exp=1", valid); end
        if (data_out !== 8'hA5) begin nMismatched++; $display("[TB] FAIL perr_data got=%h exp=a5", data_out); end
        if (parity_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL perr_flag got=%b exp=1", parity_err); end
        consume_one();
    endtask

    task automatic test_frame_error();
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        nCompared += 2;
        if (frame_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL ferr_pulse got=%b exp=1", frame_err); end
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL ferr_valid got=%b exp=0", valid); end
        @(posedge clk);
        #1;
        nCompared += 2;
        if (frame_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL ferr_width got=%b exp=0", frame_err); end
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL ferr_valid_late got=%b exp=0", valid); end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        nCompared += 2;
        if (valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovr_first_valid got=%b exp=1", valid); end
        if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovr_first_pulse got=%b exp=0", overrun); end
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        nCompared += 2;
        if (overrun !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovr_pulse got=%b exp=1", overrun); end
        if (data_out !== 8'h3C) begin nMismatched++; $display("[TB] FAIL ovr_data got=%h exp=3c", data_out); end
        @(posedge clk);
        #1;
        nCompared += 2;
        if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovr_width got=%b exp=0", overrun); end
        if (valid !== 1'b1 || data_out !== 8'h3C) begin
            nMismatched++;
            $display("[TB] FAIL ovr_held got v=%b d=%h exp v=1 d=3c", valid, data_out);
        end
        consume_one();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        nCompared += 2;
        if (valid !== 1'b1 || data_out !== 8'h3C) begin
            nMismatched++;
            $display("[TB] FAIL b2b_first got v=%b d=%h exp v=1 d=3c", valid, data_out);
        end
        if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_first_ovr got=%b exp=0", overrun); end
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        nCompared += 2;
        if (valid !== 1'b1 || data_out !== 8'hC3) begin
            nMismatched++;
            $display("[TB] FAIL b2b_second got v=%b d=%h exp v=1 d=c3", valid, data_out);
        end
        if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_second_ovr got=%b exp=0", overrun); end
        @(posedge clk);
        #1;
        nCompared++;
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_drained got=%b exp=0", valid); end
        ready = 1'b0;

        // Held word consumed on the same edge the next word loads.
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        send_head(8'hC3, 1'b0, 0);
        ready = 1'b1;
        send_bit(1'b1, 0);
        ready = 1'b0;
        din = 1'b1;
        nCompared += 2;
        if (valid !== 1'b1 || data_out !== 8'hC3) begin
            nMismatched++;
            $display("[TB] FAIL sameedge_load got v=%b d=%h exp v=1 d=c3", valid, data_out);
        end
        if (overrun !== 1'b0) begin nMismatched++; $display("[TB] FAIL sameedge_ovr got=%b exp=0", overrun); end
        consume_one();
    endtask

    task automatic test_reset_mid_frame(input int gap);
        ready = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 4; i++) send_bit(1'b1, gap);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_valid gap=%0d got=%b exp=0", gap, valid); end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, gap);
        nCompared += 4;
        if (valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_new_valid gap=%0d got=%b exp=1", gap, valid); end
        if (data_out !== 8'h5A) begin nMismatched++; $display("[TB] FAIL midrst_new_data gap=%0d got=%h exp=5a", gap, data_out); end
        if (parity_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_new_perr gap=%0d got=%b exp=0", gap, parity_err); end
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_pulses gap=%0d got fe/ov=%b%b exp=00", gap, frame_err, overrun);
        end
        consume_one();
        nCompared++;
        if (valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_drain gap=%0d got=%b exp=0", gap, valid); end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_idle();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame(0);
        test_reset_mid_frame(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
